// File: rtl/audio_record_ctrl.sv
// Sample-memory sequencer for the audio recorder: records ADC samples into
// a single-port synchronous RAM and plays them back one per DAC request.
//
// Ports:
//   clk, reset                : audio clock, synchronous active-high reset
//   start_rec/start_play/stop : single-cycle commands (stop > rec > play)
//   loop                      : level, playback wraps at end of recording
//   sample_end/sample_req     : ADC valid / DAC request strobes
//   audio_input/audio_out     : ADC sample in, playback sample out
//   mem_addr/mem_wdata/mem_we : registered RAM interface, mem_rdata back
//   rec_length                : number of valid stored samples
//   recording/playing         : status levels
//   full/underrun             : sticky status flags
module audio_record_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_rec,
   input  logic                  start_play,
   input  logic                  stop,
   input  logic                  loop,
   input  logic                  sample_end,
   input  logic                  sample_req,
   input  logic [DATA_WIDTH-1:0] audio_input,
   output logic [DATA_WIDTH-1:0] audio_out,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH:0]   rec_length,
   output logic                  recording,
   output logic                  playing,
   output logic                  full,
   output logic                  underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REC,
      S_FETCH,
      S_WAIT,
      S_PLAY
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_played;
   logic [DATA_WIDTH-1:0] r_next_sample;
   logic [DATA_WIDTH-1:0] r_audio_out;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_mem_we;
   logic [ADDR_WIDTH:0]   r_rec_length;
   logic                  r_recording;
   logic                  r_playing;
   logic                  r_full;
   logic                  r_underrun;

   logic                  w_play_ok;
   logic                  w_wr_last;
   logic [ADDR_WIDTH-1:0] w_rd_nx;
   logic [ADDR_WIDTH:0]   w_played_nx;
   logic [ADDR_WIDTH:0]   w_wr_len;

   // start_play with nothing recorded is treated as no command at all
   assign w_play_ok   = start_play && (r_rec_length != '0);
   assign w_wr_last   = &r_wr_ptr;
   assign w_rd_nx     = r_rd_ptr + 1'b1;
   assign w_played_nx = r_played + 1'b1;
   assign w_wr_len    = {1'b0, r_wr_ptr} + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_played      <= '0;
         r_next_sample <= '0;
         r_audio_out   <= '0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_we      <= 1'b0;
         r_rec_length  <= '0;
         r_recording   <= 1'b0;
         r_playing     <= 1'b0;
         r_full        <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         if (stop) begin
            r_state     <= S_IDLE;
            r_recording <= 1'b0;
            r_playing   <= 1'b0;
         end else if (start_rec) begin
            r_wr_ptr     <= '0;
            r_rec_length <= '0;
            r_full       <= 1'b0;
            r_state      <= S_REC;
            r_recording  <= 1'b1;
            r_playing    <= 1'b0;
         end else if (w_play_ok) begin
            // Address goes out on entry so FETCH presents it to the RAM
            r_rd_ptr    <= '0;
            r_played    <= '0;
            r_underrun  <= 1'b0;
            r_mem_addr  <= '0;
            r_state     <= S_FETCH;
            r_playing   <= 1'b1;
            r_recording <= 1'b0;
         end else begin
            case (r_state)
               S_REC: begin
                  if (sample_req) r_audio_out <= '0;
                  if (sample_end) begin
                     r_mem_we     <= 1'b1;
                     r_mem_addr   <= r_wr_ptr;
                     r_mem_wdata  <= audio_input;
                     r_wr_ptr     <= r_wr_ptr + 1'b1;
                     r_rec_length <= w_wr_len;
                     // Memory full: stop here, never wrap
                     if (w_wr_last) begin
                        r_full      <= 1'b1;
                        r_state     <= S_IDLE;
                        r_recording <= 1'b0;
                     end
                  end
               end
               S_FETCH: begin
                  if (sample_req) begin
                     r_audio_out <= '0;
                     r_underrun  <= 1'b1;
                  end
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (sample_req) begin
                     r_audio_out <= '0;
                     r_underrun  <= 1'b1;
                  end
                  r_next_sample <= mem_rdata;
                  r_state       <= S_PLAY;
               end
               S_PLAY: begin
                  if (sample_req) begin
                     r_audio_out <= r_next_sample;
                     if (w_played_nx == r_rec_length) begin
                        if (loop) begin
                           r_rd_ptr   <= '0;
                           r_played   <= '0;
                           r_mem_addr <= '0;
                           r_state    <= S_FETCH;
                        end else begin
                           r_played  <= w_played_nx;
                           r_state   <= S_IDLE;
                           r_playing <= 1'b0;
                        end
                     end else begin
                        r_played   <= w_played_nx;
                        r_rd_ptr   <= w_rd_nx;
                        r_mem_addr <= w_rd_nx;
                        r_state    <= S_FETCH;
                     end
                  end
               end
               default: begin
                  if (sample_req) r_audio_out <= '0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign audio_out  = r_audio_out;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_we     = r_mem_we;
   assign rec_length = r_rec_length;
   assign recording  = r_recording;
   assign playing    = r_playing;
   assign full       = r_full;
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_audio_record_ctrl.sv
// Testbench for audio_record_ctrl: randomized record/playback against a
// queue-based model of the recorder, plus directed corner cases.
module tb_audio_record_ctrl;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_rec;
   logic          start_play;
   logic          stop;
   logic          loop;
   logic          sample_end;
   logic          sample_req;
   logic [DW-1:0] audio_input;
   logic [DW-1:0] audio_out;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic [AW:0]   rec_length;
   logic          recording;
   logic          playing;
   logic          full;
   logic          underrun;

   int n_tot = 0;
   int n_bad = 0;

   logic [DW-1:0] ram [D];
   int            wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];
   logic [DW-1:0] model[$];

   audio_record_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_rec(start_rec),
      .start_play(start_play),
      .stop(stop),
      .loop(loop),
      .sample_end(sample_end),
      .sample_req(sample_req),
      .audio_input(audio_input),
      .audio_out(audio_out),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we(mem_we),
      .mem_rdata(mem_rdata),
      .rec_length(rec_length),
      .recording(recording),
      .playing(playing),
      .full(full),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, read data one cycle after address
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(mem_wdata);
      end
      mem_rdata <= ram[mem_addr];
   end

   task chk(input string tag, input logic [31:0] got,
            input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task pulse_rec();
      start_rec = 1'b1;
      tick();
      start_rec = 1'b0;
   endtask

   task pulse_play();
      start_play = 1'b1;
      tick();
      start_play = 1'b0;
   endtask

   task pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task chk_reset_vals(input string tag);
      chk({tag, "_aout"}, audio_out, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_len"}, rec_length, 0);
      chk({tag, "_rec"}, recording, 0);
      chk({tag, "_play"}, playing, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_unr"}, underrun, 0);
   endtask

   task fill_model(input int n);
      logic [31:0] r;
      model = {};
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         model.push_back(r[DW-1:0]);
      end
   endtask

   // Record every model sample (model.size() <= D), then stop
   task record_model(input int gap);
      int len;
      len = model.size();
      pulse_rec();
      for (int i = 0; i < len; i++) begin
         sample_end  = 1'b1;
         audio_input = model[i];
         tick();
         sample_end  = 1'b0;
         audio_input = 16'h0BAD;
         chk("wr_we", mem_we, 1);
         chk("wr_addr", mem_addr, i);
         chk("wr_data", mem_wdata, model[i]);
         chk("wr_recflag", recording, (i == D - 1) ? 0 : 1);
         tick();
         chk("wr_we_off", mem_we, 0);
         tick(gap);
      end
      pulse_stop();
      chk("rec_len", rec_length, len);
      chk("rec_off", recording, 0);
      chk("rec_full", full, (len == D) ? 1 : 0);
   endtask

   // Expected k-th output: loop wraps over the recording, otherwise
   // silence once the recording is exhausted
   task play_model(input bit lp, input int nreq, input int gap);
      int len;
      logic [DW-1:0] exp;
      len  = model.size();
      loop = lp;
      pulse_play();
      tick(gap);
      for (int k = 0; k < nreq; k++) begin
         sample_req = 1'b1;
         tick();
         sample_req = 1'b0;
         if (lp)           exp = model[k % len];
         else if (k < len) exp = model[k];
         else              exp = '0;
         chk("play_aout", audio_out, exp);
         chk("play_flag", playing, (lp || (k + 1 < len)) ? 1 : 0);
         tick(gap);
      end
      chk("play_unr", underrun, 0);
      pulse_stop();
      loop = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      start_rec   = 1'b0;
      start_play  = 1'b0;
      stop        = 1'b0;
      loop        = 1'b0;
      sample_end  = 1'b0;
      sample_req  = 1'b0;
      audio_input = '0;
      tick(3);
      chk_reset_vals("rst");
      reset = 1'b0;
      tick();
      chk_reset_vals("post_rst");

      // Three directed samples, then one-shot playback with a spare request
      model = {16'h1111, 16'h2222, 16'h3333};
      record_model(18);
      play_model(1'b0, 4, 19);

      // Fill: ten strobes, only eight land in memory
      fill_model(10);
      wr_addr_q = {};
      wr_data_q = {};
      pulse_rec();
      for (int i = 0; i < 10; i++) begin
         sample_end  = 1'b1;
         audio_input = model[i];
         tick();
         sample_end  = 1'b0;
         chk("fill_we", mem_we, (i < D) ? 1 : 0);
         if (i == D - 1) begin
            chk("fill_full", full, 1);
            chk("fill_recflag", recording, 0);
            chk("fill_len", rec_length, D);
         end
         tick(2);
      end
      chk("fill_nwr", wr_addr_q.size(), D);
      for (int i = 0; i < D; i++) begin
         chk("fill_addr", wr_addr_q[i], i);
         chk("fill_data", wr_data_q[i], model[i]);
      end
      chk("fill_len_end", rec_length, D);
      while (model.size() > D) void'(model.pop_back());
      play_model(1'b1, 10, 5);

      // Loop over a two-sample recording
      model = {16'hAAAA, 16'hBBBB};
      record_model(3);
      play_model(1'b1, 5, 6);

      // Randomized record/playback rounds
      for (int r = 0; r < 6; r++) begin
         fill_model($urandom_range(1, D));
         record_model($urandom_range(2, 6));
         play_model(1'($urandom_range(0, 1)),
                    $urandom_range(1, 2 * model.size() + 2),
                    $urandom_range(4, 8));
      end

      // Request arriving while the first sample is still being fetched
      model = {16'hAAAA, 16'hBBBB};
      record_model(3);
      play_model(1'b1, 1, 5);
      chk("unr_pre_aout", audio_out, 16'hAAAA);
      start_play = 1'b1;
      tick();
      start_play = 1'b0;
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      chk("unr_aout", audio_out, 0);
      chk("unr_flag", underrun, 1);
      chk("unr_playing", playing, 1);
      pulse_stop();

      // start_rec beats start_play
      start_rec  = 1'b1;
      start_play = 1'b1;
      tick();
      start_rec  = 1'b0;
      start_play = 1'b0;
      chk("pri_rec", recording, 1);
      chk("pri_play", playing, 0);
      chk("pri_len", rec_length, 0);

      // stop beats a same-cycle sample_end
      wr_addr_q = {};
      stop        = 1'b1;
      sample_end  = 1'b1;
      audio_input = 16'h7777;
      tick();
      stop       = 1'b0;
      sample_end = 1'b0;
      chk("stop_we", mem_we, 0);
      chk("stop_rec", recording, 0);
      tick();
      chk("stop_nwr", wr_addr_q.size(), 0);

      // Reset in the middle of recording
      pulse_rec();
      sample_end  = 1'b1;
      audio_input = 16'h5A5A;
      tick();
      chk("mid_we", mem_we, 1);
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      sample_end = 1'b0;
      chk_reset_vals("mid_rst");

      // Playback request with an empty recording is ignored
      pulse_play();
      chk("empty_play", playing, 0);
      tick(3);
      chk("empty_play2", playing, 0);
      chk("empty_addr", mem_addr, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
